// File: rtl/reset_sequencer.sv
// Power-on / software / watchdog reset sequencer: synchronises the board reset,
// stretches it, then releases NCH active-low reset channels one after another.
module reset_sequencer #(
    parameter int          NCH         = 3,
    parameter int          HOLD_CYCLES = 256,
    parameter int          STAGE_GAP   = 16,
    parameter int unsigned WDT_TIMEOUT = 24'd10000000,
    parameter int          WDT_W       = 24
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           sw_rst_req,
    input  logic           wdt_en,
    input  logic           wdt_kick,
    output logic [NCH-1:0] rst_out_n,
    output logic           all_released,
    output logic [1:0]     rst_cause
);

    localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam int STAGE_W = $clog2(STAGE_GAP + 1);
    localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STAGE_W-1:0] GAP_LAST  = STAGE_W'(STAGE_GAP - 1);
    localparam logic [CH_W-1:0]    CH_LAST   = CH_W'(NCH - 1);
    localparam logic [WDT_W-1:0]   WDT_LAST  = WDT_W'(WDT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_HOLD,
        S_STAGE,
        S_RUN
    } state_t;

    state_t             state;
    logic [1:0]         sync_ff;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [STAGE_W-1:0] stage_cnt;
    logic [CH_W-1:0]    chan_idx;
    logic [WDT_W-1:0]   wdt_cnt;
    logic               wdt_expire;
    logic               trigger;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= 2'b00;
        end else begin
            sync_ff <= {sync_ff[0], 1'b1};
        end
    end

    // A kick in the expiry cycle clears the counter instead of firing.
    assign wdt_expire = (state == S_RUN) && wdt_en && !wdt_kick && (wdt_cnt == WDT_LAST);
    assign trigger    = (state == S_RUN) && (sw_rst_req || wdt_expire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_HOLD;
            hold_cnt     <= '0;
            stage_cnt    <= '0;
            chan_idx     <= '0;
            wdt_cnt      <= '0;
            rst_out_n    <= '0;
            all_released <= 1'b0;
            rst_cause    <= 2'b00;
        end else begin
            case (state)
                S_HOLD: begin
                    wdt_cnt <= '0;
                    // Counting only begins once the synchronised reset has released.
                    if (sync_ff[1]) begin
                        if (hold_cnt == HOLD_LAST) begin
                            rst_out_n[0] <= 1'b1;
                            stage_cnt    <= '0;
                            chan_idx     <= CH_W'(1);
                            if (NCH == 1) begin
                                state        <= S_RUN;
                                all_released <= 1'b1;
                            end else begin
                                state <= S_STAGE;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end

                S_STAGE: begin
                    wdt_cnt <= '0;
                    if (stage_cnt == GAP_LAST) begin
                        rst_out_n[chan_idx] <= 1'b1;
                        stage_cnt           <= '0;
                        if (chan_idx == CH_LAST) begin
                            state        <= S_RUN;
                            all_released <= 1'b1;
                        end else begin
                            chan_idx <= chan_idx + 1'b1;
                        end
                    end else begin
                        stage_cnt <= stage_cnt + 1'b1;
                    end
                end

                S_RUN: begin
                    // Watchdog has priority over software when both fire together.
                    if (trigger) begin
                        rst_out_n    <= '0;
                        all_released <= 1'b0;
                        rst_cause    <= wdt_expire ? 2'b10 : 2'b01;
                        state        <= S_HOLD;
                        hold_cnt     <= '0;
                        stage_cnt    <= '0;
                        chan_idx     <= '0;
                        wdt_cnt      <= '0;
                    end else if (!wdt_en || wdt_kick) begin
                        wdt_cnt <= '0;
                    end else if (wdt_cnt != WDT_LAST) begin
                        wdt_cnt <= wdt_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= S_HOLD;
                end
            endcase
        end
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised successor to the fixed 256-cycle power-on reset counter in the board top levels.
- Synchronises the raw board reset and stretches it, then releases NCH reset channels in a staged order: core, memories, localbus/peripherals.
- Also regenerates the reset on a software request from the localbus or on a watchdog timeout.
- Keeps a sticky reset-cause code that firmware reads.

Parameters:
- NCH, 3, number of staged reset output channels (>=1).
- HOLD_CYCLES, 256, cycles all channels stay asserted after the synchronised release (>=1).
- STAGE_GAP, 16, cycles between release of channel i and channel i+1 (>=1).
- WDT_TIMEOUT, 24'd10000000, watchdog expiry period in cycles (>=2).
- WDT_W, 24, watchdog counter width; must hold WDT_TIMEOUT.

Ports:
- clk  in  1  system clock
- rst_n  in  1  raw board/power-on reset; asynchronous, active-low
- sw_rst_req  in  1  software reset request; single-cycle pulse from a localbus register write
- wdt_en  in  1  watchdog enable (level)
- wdt_kick  in  1  watchdog service pulse
- rst_out_n  out  NCH  staged active-low resets; bit 0 is released first
- all_released  out  1  high when every rst_out_n bit is high
- rst_cause  out  2  last reset source: 00 external/power-on, 01 software, 10 watchdog, 11 unused

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low on rst_n.
- rst_n low, asynchronous:
  - rst_out_n = 0, all_released = 0, rst_cause = 00.
  - FSM = HOLD, all counters = 0.
  - 2-flop synchroniser cleared.
- rst_n release:
  - Passes through the 2-flop synchroniser.
  - T0 = the 2nd rising edge after rst_n goes high; the FSM starts counting at T0.
- FSM states:
  - HOLD: hold counter increments each cycle. After HOLD_CYCLES cycles, go to STAGE and set rst_out_n[0] = 1 on edge T0+HOLD_CYCLES.
  - STAGE: stage counter runs. rst_out_n[i] goes high on edge T0+HOLD_CYCLES+i*STAGE_GAP. When the last channel releases, go to RUN and set all_released = 1 on that same edge.
  - RUN: all channels released. Watchdog and sw_rst_req are active.
- Outputs: all are registered, with no combinational path from inputs to outputs. Release is monotonic: within a sequence, a released channel never re-asserts except by a new trigger.
- Watchdog, active only in RUN:
  - Counter is cleared when wdt_en = 0, on any cycle with wdt_kick = 1, and in HOLD/STAGE.
  - Otherwise it increments by 1 per cycle.
  - Expiry: counter == WDT_TIMEOUT-1 with wdt_en = 1 and no kick that cycle.
  - Kick on the expiry cycle wins: the counter clears and there is no trigger.
- Trigger in RUN (sw_rst_req or expiry), effective next edge:
  - rst_out_n = 0, all_released = 0.
  - rst_cause = 01 (software) or 10 (watchdog).
  - FSM = HOLD with counters cleared.
  - The sequence then repeats with T0 = that edge.
- Simultaneous sw_rst_req and watchdog expiry: watchdog wins, rst_cause = 10.
- sw_rst_req or wdt activity during HOLD/STAGE: ignored. Timing is unchanged and rst_cause is unchanged.
- rst_cause is sticky. It changes only on a trigger or on rst_n assertion, and it is not cleared by the block's own rst_out_n.
- rst_n asserted mid-HOLD/STAGE/RUN: immediate asynchronous return to the reset values, including rst_cause = 00. The sequence restarts from a fresh T0 after release.
- Widths:
  - Hold and stage counters are sized by $clog2 of their maximum count +1.
  - No wrap-around is permitted; counters saturate at the terminal value.
  - WDT_W must hold WDT_TIMEOUT.

Test Plan:
Bench parameters: NCH=3, HOLD_CYCLES=8, STAGE_GAP=4, WDT_TIMEOUT=20.
1. rst_n low 5 cycles, then high -> rst_out_n = 000 throughout. Then 001 at T0+8, 011 at T0+12, 111 and all_released = 1 at T0+16; rst_cause = 00.
2. In RUN, 1-cycle sw_rst_req -> next edge rst_out_n = 000, all_released = 0, rst_cause = 01. Re-release at +8/+12/+16 from that edge.
3. In RUN, wdt_en = 1 with no kicks -> trigger on the 20th cycle, rst_cause = 10. Repeat with a wdt_kick every 10 cycles for 200 cycles -> no trigger; rst_out_n stays 111.
4. sw_rst_req on the same cycle as watchdog expiry -> single trigger, rst_cause = 10. Kick on the expiry cycle -> no trigger.
5. rst_n asserted at T0+13, mid-STAGE with rst_out_n = 011 -> rst_out_n = 000 before the next edge, rst_cause = 00. After release the full 8/12/16 sequence repeats from the new T0.
6. sw_rst_req pulsed at T0+3 (HOLD) and T0+10 (STAGE) -> ignored; release edges unchanged at 8/12/16; rst_cause unchanged.
